// File: rtl/trdb_packet_select.sv
// trdb_packet_select: E-trace packet format selector.
// Tracks nc/tc/lc history, branch map and resync state; one request per cycle.
module trdb_packet_select #(
    parameter int XLEN           = 32,
    parameter int BRANCH_MAP_LEN = 31,
    parameter int RESYNC_MAX     = 256,
    parameter int CNT_W          = $clog2(BRANCH_MAP_LEN + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      qualified_i,
    input  logic                      retired_i,
    input  logic                      exception_i,
    input  logic                      updiscon_i,
    input  logic                      is_branch_i,
    input  logic                      taken_i,
    input  logic                      ppccd_i,
    input  logic                      imprecise_ctx_i,
    input  logic                      support_req_i,
    input  logic [XLEN-1:0]           iaddr_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [1:0]                format_o,
    output logic [1:0]                subformat_o,
    output logic                      thaddr_o,
    output logic [CNT_W-1:0]          branches_o,
    output logic [BRANCH_MAP_LEN-1:0] branch_map_o,
    output logic [XLEN-1:0]           iaddr_o
);

    localparam int RS_W = $clog2(RESYNC_MAX);
    localparam logic [RS_W-1:0] RS_TOP = RS_W'(RESYNC_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BRANCH_MAP_LEN);

    typedef enum logic [1:0] {
        FMT_F0 = 2'd0,
        FMT_F1 = 2'd1,
        FMT_F2 = 2'd2,
        FMT_F3 = 2'd3
    } fmt_e;

    typedef struct packed {
        logic            valid;
        logic            qualified;
        logic            retired;
        logic            exception;
        logic            updiscon;
        logic            is_branch;
        logic            taken;
        logic            ppccd;
        logic            imprecise;
        logic [XLEN-1:0] iaddr;
    } rec_t;

    rec_t nc, tc_q;
    logic lc_exc_q, lc_upd_q;

    logic [BRANCH_MAP_LEN-1:0] map_q, map_d, map_inc, map_bit;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [RS_W-1:0]           rs_cnt_q, rs_cnt_d;
    logic                      rs_pend_q, rs_pend_d;
    logic                      first_q, first_d;
    logic                      rep_q, rep_d;
    logic                      sup_q, sup_d;

    logic                      valid_q, valid_d;
    fmt_e                      fmt_q, fmt_d;
    logic [1:0]                sub_q, sub_d;
    logic                      th_q, th_d;
    logic [CNT_W-1:0]          br_q, br_d;
    logic [BRANCH_MAP_LEN-1:0] bmap_q, bmap_d;
    logic [XLEN-1:0]           addr_q, addr_d;

    logic stall;
    logic tc_ok, tc_exc_only, tc_ern, nc_ok, nc_exc_only;
    logic emit, use_addr, th;
    fmt_e fmt;
    logic [1:0] sub;
    logic clr_map, clr_rs;

    assign stall   = valid_q && !ready_i;
    assign ready_o = !stall;

    always_comb begin
        nc = '0;
        if (valid_i) begin
            nc.valid     = 1'b1;
            nc.qualified = qualified_i;
            nc.retired   = retired_i;
            nc.exception = exception_i;
            nc.updiscon  = updiscon_i;
            nc.is_branch = is_branch_i;
            nc.taken     = taken_i;
            nc.ppccd     = ppccd_i;
            nc.imprecise = imprecise_ctx_i;
            nc.iaddr     = iaddr_i;
        end
    end

    assign tc_ok = tc_q.valid && tc_q.qualified
                && (tc_q.retired || tc_q.exception);
    assign tc_exc_only = tc_q.exception && !tc_q.retired;
    assign tc_ern      = tc_q.exception && tc_q.retired;
    assign nc_ok       = nc.valid && nc.qualified;
    assign nc_exc_only = nc.exception && !nc.retired;

    // The branch retiring in tc is folded in before the packet decision.
    always_comb begin
        map_bit    = '0;
        map_bit[0] = !tc_q.taken;
        map_inc    = map_q;
        cnt_inc    = cnt_q;
        if (tc_ok && tc_q.is_branch) begin
            map_inc = map_q | (map_bit << cnt_q);
            cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        emit     = 1'b0;
        use_addr = 1'b0;
        fmt      = FMT_F0;
        sub      = 2'd0;
        th       = 1'b0;
        if (tc_ok) begin
            if (lc_exc_q) begin
                emit = 1'b1;
                fmt  = FMT_F3;
                if (tc_exc_only) begin
                    sub = 2'd1;
                end else if (!rep_q) begin
                    sub = 2'd1;
                    th  = 1'b1;
                end
            end else if (first_q || tc_q.ppccd || rs_pend_q) begin
                emit = 1'b1;
                fmt  = FMT_F3;
            end else if (lc_upd_q) begin
                if (tc_q.exception) begin
                    emit = 1'b1;
                    fmt  = FMT_F3;
                    sub  = 2'd1;
                end else begin
                    use_addr = 1'b1;
                end
            end else if (tc_ern) begin
                use_addr = 1'b1;
            end else if (nc_exc_only || !nc_ok
                         || (nc.ppccd && cnt_inc != '0)) begin
                use_addr = 1'b1;
            end else if (cnt_inc == CNT_FULL) begin
                emit = 1'b1;
            end else if (tc_q.imprecise) begin
                emit = 1'b1;
                fmt  = FMT_F3;
                sub  = 2'd2;
            end else if (sup_q) begin
                emit = 1'b1;
                fmt  = FMT_F3;
                sub  = 2'd3;
            end
        end
        if (use_addr) begin
            emit = 1'b1;
            fmt  = (cnt_inc == '0) ? FMT_F2 : FMT_F1;
        end
    end

    assign clr_rs  = emit && fmt == FMT_F3 && !sub[1];
    assign clr_map = emit && (fmt == FMT_F0 || fmt == FMT_F1 || clr_rs);

    always_comb begin
        map_d     = clr_map ? '0 : map_inc;
        cnt_d     = clr_map ? '0 : cnt_inc;
        rs_cnt_d  = rs_cnt_q;
        rs_pend_d = rs_pend_q;
        if (tc_ok) begin
            if (rs_cnt_q != RS_TOP) rs_cnt_d = rs_cnt_q + RS_W'(1);
            if (rs_cnt_d == RS_TOP) rs_pend_d = 1'b1;
        end
        if (clr_rs) begin
            rs_cnt_d  = '0;
            rs_pend_d = 1'b0;
        end
        first_d = first_q;
        if (tc_ok) first_d = 1'b0;
        else if (!(tc_q.valid && tc_q.qualified)) first_d = 1'b1;
        rep_d = rep_q;
        if (emit && fmt == FMT_F3 && sub == 2'd1 && !th) rep_d = 1'b1;
        else if (tc_ok) rep_d = 1'b0;
        // A request survives until an F3SF3 actually goes out.
        sup_d = (sup_q && !(emit && fmt == FMT_F3 && sub == 2'd3))
             || support_req_i;
    end

    always_comb begin
        valid_d = emit;
        fmt_d   = fmt_q;
        sub_d   = sub_q;
        th_d    = th_q;
        br_d    = br_q;
        bmap_d  = bmap_q;
        addr_d  = addr_q;
        if (emit) begin
            fmt_d  = fmt;
            sub_d  = sub;
            th_d   = th;
            br_d   = (fmt == FMT_F1) ? cnt_inc : '0;
            bmap_d = map_inc;
            addr_d = tc_q.iaddr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tc_q      <= '0;
            lc_exc_q  <= 1'b0;
            lc_upd_q  <= 1'b0;
            map_q     <= '0;
            cnt_q     <= '0;
            rs_cnt_q  <= '0;
            rs_pend_q <= 1'b0;
            first_q   <= 1'b1;
            rep_q     <= 1'b0;
            sup_q     <= 1'b0;
            valid_q   <= 1'b0;
            fmt_q     <= FMT_F0;
            sub_q     <= 2'd0;
            th_q      <= 1'b0;
            br_q      <= '0;
            bmap_q    <= '0;
            addr_q    <= '0;
        end else if (!stall) begin
            tc_q      <= nc;
            lc_exc_q  <= tc_ok && tc_q.exception;
            lc_upd_q  <= tc_ok && tc_q.updiscon;
            map_q     <= map_d;
            cnt_q     <= cnt_d;
            rs_cnt_q  <= rs_cnt_d;
            rs_pend_q <= rs_pend_d;
            first_q   <= first_d;
            rep_q     <= rep_d;
            sup_q     <= sup_d;
            valid_q   <= valid_d;
            fmt_q     <= fmt_d;
            sub_q     <= sub_d;
            th_q      <= th_d;
            br_q      <= br_d;
            bmap_q    <= bmap_d;
            addr_q    <= addr_d;
        end
    end

    assign valid_o      = valid_q;
    assign format_o     = fmt_q;
    assign subformat_o  = sub_q;
    assign thaddr_o     = th_q;
    assign branches_o   = br_q;
    assign branch_map_o = bmap_q;
    assign iaddr_o      = addr_q;

endmodule

// File: tb/tb_trdb_packet_select.sv
// tb_trdb_packet_select: directed vectors for the packet selector.
// A second instance runs with RESYNC_MAX=4 for the resync case.
module tb_trdb_packet_select;

    localparam logic [5:0] P_F0   = 6'b1_00_00_0;
    localparam logic [5:0] P_F1   = 6'b1_01_00_0;
    localparam logic [5:0] P_F2   = 6'b1_10_00_0;
    localparam logic [5:0] P_S0   = 6'b1_11_00_0;
    localparam logic [5:0] P_S1T0 = 6'b1_11_01_0;
    localparam logic [5:0] P_S3   = 6'b1_11_11_0;

    // {imprecise, ppccd, taken, is_branch, updiscon, exception, retired, qualified}
    localparam logic [7:0] R  = 8'h03;
    localparam logic [7:0] BN = 8'h13;
    localparam logic [7:0] BT = 8'h33;
    localparam logic [7:0] UP = 8'h0B;
    localparam logic [7:0] EX = 8'h05;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, vin, qual, ret, exc, upd, isbr, tkn, ppccd, impr, sup, rdy;
    logic [31:0] iaddr;

    logic        ready_o, valid_o, thaddr_o;
    logic [1:0]  format_o, subformat_o;
    logic [4:0]  branches_o;
    logic [30:0] branch_map_o;
    logic [31:0] iaddr_o;

    logic        r_ready, r_valid, r_th;
    logic [1:0]  r_fmt, r_sub;
    logic [4:0]  r_br;
    logic [30:0] r_map;
    logic [31:0] r_addr;

    int nvec = 0;
    int nerr = 0;

    trdb_packet_select dut (
        .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(ready_o),
        .qualified_i(qual), .retired_i(ret), .exception_i(exc),
        .updiscon_i(upd), .is_branch_i(isbr), .taken_i(tkn),
        .ppccd_i(ppccd), .imprecise_ctx_i(impr), .support_req_i(sup),
        .iaddr_i(iaddr), .valid_o(valid_o), .ready_i(rdy),
        .format_o(format_o), .subformat_o(subformat_o),
        .thaddr_o(thaddr_o), .branches_o(branches_o),
        .branch_map_o(branch_map_o), .iaddr_o(iaddr_o)
    );

    trdb_packet_select #(.RESYNC_MAX(4)) dut_r (
        .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(r_ready),
        .qualified_i(qual), .retired_i(ret), .exception_i(exc),
        .updiscon_i(upd), .is_branch_i(isbr), .taken_i(tkn),
        .ppccd_i(ppccd), .imprecise_ctx_i(impr), .support_req_i(sup),
        .iaddr_i(iaddr), .valid_o(r_valid), .ready_i(rdy),
        .format_o(r_fmt), .subformat_o(r_sub),
        .thaddr_o(r_th), .branches_o(r_br),
        .branch_map_o(r_map), .iaddr_o(r_addr)
    );

    function automatic logic [5:0] pk();
        return {valid_o, format_o, subformat_o, thaddr_o};
    endfunction

    function automatic logic [5:0] rpk();
        return {r_valid, r_fmt, r_sub, r_th};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] fl,
                          input logic [31:0] a, input logic s);
        vin = v;
        {impr, ppccd, tkn, isbr, upd, exc, ret, qual} = fl;
        iaddr = a;
        sup = s;
    endtask

    task automatic put(input logic v, input logic [7:0] fl,
                       input logic [31:0] a, input logic s);
        set_in(v, fl, a, s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 8'h00, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rdy = 1'b1;
        do_reset();
        chk("rst.valid", valid_o, 0);
        chk("rst.ready", ready_o, 1);
        chk("rst.fmt", {format_o, subformat_o, thaddr_o}, 0);
        chk("rst.br", branches_o, 0);
        chk("rst.map", branch_map_o, 0);
        chk("rst.addr", iaddr_o, 0);

        // first record after reset, then F2 once a bubble follows
        put(1, R, 32'h100, 0);
        chk("t1.empty", valid_o, 0);
        put(1, R, 32'h104, 0);
        chk("t1.s0", pk(), P_S0);
        chk("t1.s0a", iaddr_o, 32'h100);
        put(0, 8'h00, 32'h0, 0);
        chk("t1.f2", pk(), P_F2);
        chk("t1.f2a", iaddr_o, 32'h104);
        put(0, 8'h00, 32'h0, 0);
        chk("t1.none", valid_o, 0);

        // full branch map of not-taken branches
        put(1, R, 32'h200, 0);
        for (int i = 0; i < 31; i++) begin
            put(1, BN, 32'h204 + 32'(4 * i), 0);
            if (i == 0) chk("t2.s0", pk(), P_S0);
            else chk("t2.none", valid_o, 0);
        end
        put(1, R, 32'h300, 0);
        chk("t2.f0", pk(), P_F0);
        chk("t2.f0a", iaddr_o, 32'h27C);
        chk("t2.f0br", branches_o, 0);
        chk("t2.f0map", branch_map_o, 32'h7FFF_FFFF);
        put(1, R, 32'h304, 0);
        chk("t2.none2", valid_o, 0);
        put(0, 8'h00, 32'h0, 0);
        chk("t2.f2", pk(), P_F2);
        chk("t2.f2a", iaddr_o, 32'h304);
        chk("t2.f2map", branch_map_o, 0);
        put(0, 8'h00, 32'h0, 0);

        // T,N,T then updiscon then plain record
        put(1, R, 32'h400, 0);
        put(1, BT, 32'h404, 0);
        chk("t3.s0", pk(), P_S0);
        put(1, BN, 32'h408, 0);
        chk("t3.n1", valid_o, 0);
        put(1, BT, 32'h40C, 0);
        chk("t3.n2", valid_o, 0);
        put(1, UP, 32'h410, 0);
        chk("t3.n3", valid_o, 0);
        put(1, R, 32'h500, 0);
        chk("t3.n4", valid_o, 0);
        put(1, R, 32'h504, 0);
        chk("t3.f1", pk(), P_F1);
        chk("t3.f1br", branches_o, 3);
        chk("t3.f1map", branch_map_o, 32'h2);
        chk("t3.f1a", iaddr_o, 32'h500);
        put(0, 8'h00, 32'h0, 0);
        chk("t3.f2", pk(), P_F2);
        chk("t3.f2a", iaddr_o, 32'h504);
        put(0, 8'h00, 32'h0, 0);
        chk("t3.none", valid_o, 0);

        // exception without retirement after an updiscon
        put(1, R, 32'h600, 0);
        put(1, UP, 32'h604, 0);
        chk("t4.s0", pk(), P_S0);
        put(1, EX, 32'h700, 0);
        chk("t4.f2", pk(), P_F2);
        chk("t4.f2a", iaddr_o, 32'h604);
        put(1, R, 32'h800, 0);
        chk("t4.s1", pk(), P_S1T0);
        chk("t4.s1a", iaddr_o, 32'h700);
        put(1, R, 32'h804, 0);
        chk("t4.rep", pk(), P_S0);
        chk("t4.repa", iaddr_o, 32'h800);
        put(0, 8'h00, 32'h0, 0);
        chk("t4.f2b", pk(), P_F2);
        put(0, 8'h00, 32'h0, 0);
        chk("t4.none", valid_o, 0);

        // periodic resync with RESYNC_MAX=4
        do_reset();
        for (int i = 0; i < 10; i++) begin
            put(1, R, 32'h900 + 32'(4 * i), 0);
            if (i >= 1) begin
                if ((i - 1) % 4 == 0) begin
                    chk("t5.s0", rpk(), P_S0);
                    chk("t5.s0a", r_addr, 32'h900 + 32'(4 * (i - 1)));
                end else begin
                    chk("t5.none", r_valid, 0);
                end
            end
            if (i == 5) chk("t5.main", valid_o, 0);
        end
        put(0, 8'h00, 32'h0, 0);
        chk("t5.f2", rpk(), P_F2);
        chk("t5.f2a", r_addr, 32'h924);
        put(0, 8'h00, 32'h0, 0);

        // back-pressure freezes everything, support request ignored
        put(1, R, 32'hA00, 0);
        put(1, R, 32'hA04, 0);
        chk("t6.s0", pk(), P_S0);
        rdy = 1'b0;
        set_in(1, R, 32'hA08, 1);
        #1;
        chk("t6.rdy", ready_o, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            sup = 1'b0;
            chk("t6.hold", pk(), P_S0);
            chk("t6.holda", iaddr_o, 32'hA00);
            chk("t6.stall", ready_o, 0);
        end
        rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("t6.rel", valid_o, 0);
        put(1, R, 32'hA0C, 0);
        chk("t6.nosup", valid_o, 0);
        put(1, R, 32'hA10, 1);
        chk("t6.n2", valid_o, 0);
        put(1, R, 32'hA14, 0);
        chk("t6.s3", pk(), P_S3);
        chk("t6.s3a", iaddr_o, 32'hA10);
        put(1, R, 32'hA18, 0);
        chk("t6.once", valid_o, 0);
        put(0, 8'h00, 32'h0, 0);
        chk("t6.f2", pk(), P_F2);
        chk("t6.f2a", iaddr_o, 32'hA18);
        put(0, 8'h00, 32'h0, 0);

        // reset while stalled drops the request
        put(1, R, 32'hB00, 0);
        put(0, 8'h00, 32'h0, 0);
        chk("t7.s0", pk(), P_S0);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("t7.stall", ready_o, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t7.valid", valid_o, 0);
        chk("t7.ready", ready_o, 1);
        rst = 1'b0;
        rdy = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
